// File: rtl/axis_ft245_deframer.sv
// axis_ft245_deframer
//   Recovers framed host packets (SYNC, LEN, LEN payload bytes, XOR checksum)
//   from the FT245 bridge byte stream. Each frame is stored in full and
//   checked, and only good payloads are replayed downstream as one AXI-stream
//   packet with tlast. Corrupt, oversize and stalled frames are dropped and
//   reported with one-cycle status pulses.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   input_axis_*        byte stream from the FT245 bridge (tdata/tvalid/tready)
//   output_axis_*       payload stream (tdata/tvalid/tready/tlast)
//   frame_good          pulse: frame passed length and checksum checks
//   frame_err_csum      pulse: checksum mismatch
//   frame_err_len       pulse: LEN is 0 or above MAX_LEN
//   frame_err_timeout   pulse: inter-byte gap inside a frame too long
module axis_ft245_deframer #(
   parameter int         MAX_LEN        = 16,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] input_axis_tdata,
   input  logic       input_axis_tvalid,
   output logic       input_axis_tready,
   output logic [7:0] output_axis_tdata,
   output logic       output_axis_tvalid,
   input  logic       output_axis_tready,
   output logic       output_axis_tlast,
   output logic       frame_good,
   output logic       frame_err_csum,
   output logic       frame_err_len,
   output logic       frame_err_timeout
);

   localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      S_HUNT,
      S_LEN,
      S_PAYLOAD,
      S_CSUM,
      S_DRAIN
   } state_t;

   state_t        state_q;
   logic [7:0]    len_q;
   logic [7:0]    wr_ptr_q;
   logic [7:0]    rd_ptr_q;
   logic [7:0]    xor_q;
   logic [TW-1:0] tmo_q;
   logic          good_q;
   logic          err_csum_q;
   logic          err_len_q;
   logic          err_tmo_q;
   logic [7:0]    mem_q [MAX_LEN];

   logic          in_hs;
   logic          in_frame;
   logic          tmo_hit;

   assign input_axis_tready = (state_q != S_DRAIN);
   assign in_hs             = input_axis_tvalid && input_axis_tready;
   assign in_frame          = (state_q == S_LEN) || (state_q == S_PAYLOAD) ||
                              (state_q == S_CSUM);
   // Counter value one below the limit: an idle cycle here is the expiring one.
   assign tmo_hit           = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   // Outputs decode straight from the state register so an asynchronous
   // reset clears them immediately, and they cannot change while stalled.
   assign output_axis_tvalid = (state_q == S_DRAIN);
   assign output_axis_tdata  = (state_q == S_DRAIN) ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
   assign output_axis_tlast  = (state_q == S_DRAIN) && (rd_ptr_q == len_q - 8'd1);

   assign frame_good        = good_q;
   assign frame_err_csum    = err_csum_q;
   assign frame_err_len     = err_len_q;
   assign frame_err_timeout = err_tmo_q;

   // Payload store: data only, never reset.
   always_ff @(posedge clk) begin
      if ((state_q == S_PAYLOAD) && in_hs) begin
         mem_q[wr_ptr_q[AW-1:0]] <= input_axis_tdata;
      end
   end

   // Frame FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_HUNT;
         len_q      <= 8'h00;
         wr_ptr_q   <= 8'h00;
         rd_ptr_q   <= 8'h00;
         xor_q      <= 8'h00;
         tmo_q      <= '0;
         good_q     <= 1'b0;
         err_csum_q <= 1'b0;
         err_len_q  <= 1'b0;
         err_tmo_q  <= 1'b0;
      end else begin
         good_q     <= 1'b0;
         err_csum_q <= 1'b0;
         err_len_q  <= 1'b0;
         err_tmo_q  <= 1'b0;

         if (in_frame && !in_hs && tmo_hit) begin
            // Stalled frame: abandon whatever was collected.
            err_tmo_q <= 1'b1;
            state_q   <= S_HUNT;
         end else begin
            if (in_frame) begin
               tmo_q <= in_hs ? '0 : tmo_q + 1'b1;
            end
            case (state_q)
               S_HUNT: begin
                  tmo_q <= '0;
                  if (in_hs && (input_axis_tdata == SYNC_BYTE)) begin
                     state_q <= S_LEN;
                  end
               end
               S_LEN: begin
                  if (in_hs) begin
                     if ((input_axis_tdata == 8'h00) || (input_axis_tdata > MAX_LEN_B)) begin
                        err_len_q <= 1'b1;
                        state_q   <= S_HUNT;
                     end else begin
                        len_q    <= input_axis_tdata;
                        xor_q    <= input_axis_tdata;
                        wr_ptr_q <= 8'h00;
                        state_q  <= S_PAYLOAD;
                     end
                  end
               end
               S_PAYLOAD: begin
                  if (in_hs) begin
                     wr_ptr_q <= wr_ptr_q + 8'd1;
                     xor_q    <= xor_q ^ input_axis_tdata;
                     if (wr_ptr_q == len_q - 8'd1) begin
                        state_q <= S_CSUM;
                     end
                  end
               end
               S_CSUM: begin
                  if (in_hs) begin
                     if ((xor_q ^ input_axis_tdata) == 8'h00) begin
                        good_q   <= 1'b1;
                        rd_ptr_q <= 8'h00;
                        state_q  <= S_DRAIN;
                     end else begin
                        err_csum_q <= 1'b1;
                        state_q    <= S_HUNT;
                     end
                  end
               end
               S_DRAIN: begin
                  if (output_axis_tready) begin
                     if (rd_ptr_q == len_q - 8'd1) begin
                        state_q <= S_HUNT;
                     end else begin
                        rd_ptr_q <= rd_ptr_q + 8'd1;
                     end
                  end
               end
               default: state_q <= S_HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axis_ft245_deframer.sv
module tb_axis_ft245_deframer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_tdata;
   logic       in_tvalid;
   logic       in_tready;
   logic [7:0] out_tdata;
   logic       out_tvalid;
   logic       out_tready;
   logic       out_tlast;
   logic       frame_good;
   logic       frame_err_csum;
   logic       frame_err_len;
   logic       frame_err_timeout;

   always #5 clk = ~clk;

   axis_ft245_deframer #(
      .MAX_LEN(16),
      .SYNC_BYTE(8'hA5),
      .TIMEOUT_CYCLES(1024)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .input_axis_tdata(in_tdata),
      .input_axis_tvalid(in_tvalid),
      .input_axis_tready(in_tready),
      .output_axis_tdata(out_tdata),
      .output_axis_tvalid(out_tvalid),
      .output_axis_tready(out_tready),
      .output_axis_tlast(out_tlast),
      .frame_good(frame_good),
      .frame_err_csum(frame_err_csum),
      .frame_err_len(frame_err_len),
      .frame_err_timeout(frame_err_timeout)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard entries are {tlast, tdata}.
   logic [8:0] exp_q[$];
   int exp_good = 0, exp_csum = 0, exp_len = 0, exp_tmo = 0;
   int cnt_good = 0, cnt_csum = 0, cnt_len = 0, cnt_tmo = 0;
   int cyc = 0;
   int pops = 0, pop_first = 0, pop_last = 0;
   logic       toggle_en = 1'b0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data;
   logic       prev_last;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      if (toggle_en) out_tready = !out_tready;
   end

   // Output monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall) begin
            check("hold_valid", int'(out_tvalid), 1);
            check("hold_data", int'(out_tdata), int'(prev_data));
            check("hold_last", int'(out_tlast), int'(prev_last));
         end
         if (out_tvalid) check("in_ready_in_drain", int'(in_tready), 0);
         if (out_tvalid && out_tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", int'({out_tlast, out_tdata}), 0);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               check("out_data", int'(out_tdata), int'(e[7:0]));
               check("out_last", int'(out_tlast), int'(e[8]));
               if (pops == 0) pop_first = cyc;
               pop_last = cyc;
               pops++;
            end
         end
         if (frame_good | frame_err_csum | frame_err_len | frame_err_timeout)
            check("pulse_onehot",
                  $countones({frame_good, frame_err_csum, frame_err_len, frame_err_timeout}), 1);
         cnt_good += int'(frame_good);
         cnt_csum += int'(frame_err_csum);
         cnt_len  += int'(frame_err_len);
         cnt_tmo  += int'(frame_err_timeout);
         prev_stall = out_tvalid && !out_tready;
         prev_data  = out_tdata;
         prev_last  = out_tlast;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_tdata  = b;
      in_tvalid = 1'b1;
      while (!in_tready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) check("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic idle();
      in_tvalid = 1'b0;
      in_tdata  = 8'h00;
   endtask

   task automatic push_exp(input logic [7:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 500) check("drain_timeout", exp_q.size(), 0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_good"}, cnt_good, exp_good);
      check({tag, "_csum"}, cnt_csum, exp_csum);
      check({tag, "_len"},  cnt_len,  exp_len);
      check({tag, "_tmo"},  cnt_tmo,  exp_tmo);
   endtask

   initial begin
      int n;
      rst_n      = 1'b0;
      in_tvalid  = 1'b0;
      in_tdata   = 8'h00;
      out_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", int'(in_tready), 1);
      check("rst_out_valid", int'(out_tvalid), 0);
      check("rst_out_last", int'(out_tlast), 0);
      check("rst_out_data", int'(out_tdata), 0);
      check("rst_pulses", int'({frame_good, frame_err_csum, frame_err_len, frame_err_timeout}), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Good frame, first byte one cycle after checksum, one byte per cycle.
      push_exp(8'h11, 1'b0); push_exp(8'h22, 1'b0); push_exp(8'h33, 1'b1);
      exp_good++;
      pops = 0;
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
      idle();
      check("first_valid_latency", int'(out_tvalid), 1);
      wait_drain();
      check("drain_rate", pop_last - pop_first, 2);
      check_counts("good1");

      // Bad checksum then a good frame (checksum covers LEN: 02^01^02 = 01).
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      send_byte(8'h22); send_byte(8'h33); send_byte(8'h04);
      idle();
      exp_csum++;
      repeat (5) @(posedge clk);
      #1;
      check_counts("badcsum");
      push_exp(8'h01, 1'b0); push_exp(8'h02, 1'b1);
      exp_good++;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
      send_byte(8'h02); send_byte(8'h01);
      idle();
      wait_drain();
      check_counts("aftercsum");

      // Length errors, then a one-byte frame (01^7E = 7F).
      send_byte(8'hA5); send_byte(8'h00);
      send_byte(8'hA5); send_byte(8'h11);
      idle();
      exp_len += 2;
      repeat (3) @(posedge clk);
      #1;
      check_counts("lenerr");
      push_exp(8'h7E, 1'b1);
      exp_good++;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
      idle();
      wait_drain();
      check_counts("afterlen");

      // Garbage, SYNC as payload, toggling backpressure (02^A5^5A = FD).
      push_exp(8'hA5, 1'b0); push_exp(8'h5A, 1'b1);
      exp_good++;
      toggle_en = 1'b1;
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5); send_byte(8'h02);
      send_byte(8'hA5); send_byte(8'h5A); send_byte(8'hFD);
      idle();
      wait_drain();
      toggle_en = 1'b0;
      out_tready = 1'b1;
      check_counts("bp");

      // Inter-byte timeout measured from the acceptance edge of the last byte.
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
      idle();
      exp_tmo++;
      n = 0;
      while (!frame_err_timeout && n < 1100) begin
         @(posedge clk); #1;
         n++;
      end
      check("tmo_latency", n, 1024);
      repeat (3) @(posedge clk);
      #1;
      check_counts("tmo");
      push_exp(8'h42, 1'b1);
      exp_good++;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'h43);
      idle();
      wait_drain();
      check_counts("aftertmo");

      // Reset during drain after the first byte has been taken.
      push_exp(8'h11, 1'b0); push_exp(8'h22, 1'b0); push_exp(8'h33, 1'b1);
      exp_good++;
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
      idle();
      n = 0;
      while (exp_q.size() > 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rstdrain_first", exp_q.size(), 2);
      @(posedge clk); #1;
      out_tready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rstdrain_valid", int'(out_tvalid), 0);
      check("rstdrain_last", int'(out_tlast), 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_tready = 1'b1;
      @(posedge clk); #1;
      check("rstdrain_hunt_ready", int'(in_tready), 1);
      check("rstdrain_hunt_valid", int'(out_tvalid), 0);
      push_exp(8'h42, 1'b1);
      exp_good++;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'h43);
      idle();
      wait_drain();
      check_counts("final");
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
